// File: rtl/ddr3_rd_req_sched_pkg.sv
// Shared definitions for the DDR3 read-descriptor scheduler: FSM encoding,
// grant index width and descriptor field positions.
package ddr3_rd_req_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WRITE = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam int GRANT_W = 3;

  // Descriptor fields; the scheduler never decodes them, they pass through untouched
  localparam int F_MPMC_HI  = 35;
  localparam int F_MPMC_LO  = 32;
  localparam int F_ADDR_SIG = 31;
  localparam int F_ECM      = 28;
  localparam int F_IPTV     = 22;
  localparam int F_ADDR_HI  = 29;
  localparam int F_ADDR_LO  = 3;

endpackage

// File: rtl/ddr3_rd_req_sched_if.sv
// Channel-side and FIFO-side signals of the read-descriptor scheduler.
interface ddr3_rd_req_sched_if
  import ddr3_rd_req_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DW     = 36
);
  logic [NUM_CH-1:0]    ch_req;
  logic [NUM_CH*DW-1:0] ch_data;
  logic [NUM_CH-1:0]    ch_ack;
  logic [NUM_CH-1:0]    ch_ovf;
  logic [NUM_CH-1:0]    ch_credit_ret;
  logic                 rd_fifo_afull;
  logic                 rd_fifo_wreq;
  logic [DW-1:0]        rd_fifo_wdata;
  logic [GRANT_W-1:0]   grant_ch;
  logic                 credit_err;
  logic                 busy;

  modport master (
    output ch_req, ch_data, ch_ovf, ch_credit_ret, rd_fifo_afull,
    input  ch_ack, rd_fifo_wreq, rd_fifo_wdata, grant_ch, credit_err, busy
  );

  modport slave (
    input  ch_req, ch_data, ch_ovf, ch_credit_ret, rd_fifo_afull,
    output ch_ack, rd_fifo_wreq, rd_fifo_wdata, grant_ch, credit_err, busy
  );
endinterface

// File: rtl/ddr3_rd_req_sched_rr_pick.sv
// Combinational round-robin picker: first eligible channel at or after the
// pointer, wrapping modulo NUM_CH.
module ddr3_rd_req_sched_rr_pick #(
  parameter int NUM_CH = 4,
  parameter int IW     = 2
) (
  input  logic [NUM_CH-1:0] i_elig,
  input  logic [IW-1:0]     i_ptr,
  output logic [IW-1:0]     o_win,
  output logic              o_any
);
  int w_best_off;
  int w_off;

  // Smallest rotational distance from the pointer wins
  always_comb begin
    o_win      = '0;
    o_any      = 1'b0;
    w_best_off = NUM_CH;
    w_off      = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_off = k - int'(i_ptr);
      if (w_off < 0) w_off = w_off + NUM_CH;
      if (i_elig[k] && (w_off < w_best_off)) begin
        w_best_off = w_off;
        o_win      = IW'(k);
        o_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr3_rd_req_sched.sv
// Round-robin, credit-gated scheduler that feeds the DDR3 read-descriptor FIFO,
// with a fixed idle gap after each issue to leave bandwidth for writes.
module ddr3_rd_req_sched
  import ddr3_rd_req_sched_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DW         = 36,
  parameter int CREDIT_MAX = 8,
  parameter int CW         = 4,
  parameter int MIN_GAP    = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  ddr3_rd_req_sched_if.slave  bus
);
  localparam int IW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int GW       = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam int GAP_LAST = (MIN_GAP > 0) ? MIN_GAP - 1 : 0;

  state_t             r_state, w_next;
  logic [IW-1:0]      r_ptr, r_winner, w_win;
  logic               w_any;
  logic [NUM_CH-1:0]  w_elig, w_err_set, r_ack, w_ack_d;
  logic               r_wreq, w_wreq_d, w_busy;
  logic [DW-1:0]      r_wdata, w_sel_data;
  logic [GRANT_W-1:0] r_grant;
  logic [GW-1:0]      r_gap;
  logic               r_credit_err;

  ddr3_rd_req_sched_rr_pick #(.NUM_CH(NUM_CH), .IW(IW)) u_pick (
    .i_elig (w_elig),
    .i_ptr  (r_ptr),
    .o_win  (w_win),
    .o_any  (w_any)
  );

  // An ack and a return in the same cycle cancel; a return at full credit is dropped
  for (genvar k = 0; k < NUM_CH; k++) begin : g_cred
    logic [CW-1:0] r_credit;
    assign w_elig[k]    = bus.ch_req[k] & ~bus.ch_ovf[k] & (r_credit != '0);
    assign w_err_set[k] = bus.ch_credit_ret[k] & ~r_ack[k] & (r_credit == CW'(CREDIT_MAX));
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        r_credit <= CW'(CREDIT_MAX);
      else if (r_ack[k] & ~bus.ch_credit_ret[k])
        r_credit <= r_credit - CW'(1);
      else if (~r_ack[k] & bus.ch_credit_ret[k] & (r_credit != CW'(CREDIT_MAX)))
        r_credit <= r_credit + CW'(1);
    end
  end

  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (r_winner == IW'(k)) w_sel_data = bus.ch_data[k*DW +: DW];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!bus.rd_fifo_afull && w_any) w_next = S_GRANT;
      S_GRANT: w_next = S_WRITE;
      S_WRITE: w_next = (MIN_GAP > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (r_gap == GW'(GAP_LAST)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Strobes are computed one state early and registered, so they are glitch-free
  always_comb begin
    w_wreq_d = 1'b0;
    w_ack_d  = '0;
    w_busy   = (r_state != S_IDLE);
    if (r_state == S_GRANT) begin
      w_wreq_d          = 1'b1;
      w_ack_d[r_winner] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr        <= '0;
      r_winner     <= '0;
      r_gap        <= '0;
      r_wreq       <= 1'b0;
      r_ack        <= '0;
      r_wdata      <= '0;
      r_grant      <= '0;
      r_credit_err <= 1'b0;
    end else begin
      r_wreq       <= w_wreq_d;
      r_ack        <= w_ack_d;
      r_credit_err <= r_credit_err | (|w_err_set);
      r_gap        <= (r_state == S_GAP) ? r_gap + GW'(1) : '0;
      if (r_state == S_IDLE) r_winner <= w_win;
      if (r_state == S_GRANT) begin
        r_wdata <= w_sel_data;
        r_grant <= GRANT_W'(r_winner);
      end
      if (r_state == S_WRITE)
        r_ptr <= (r_winner == IW'(NUM_CH - 1)) ? '0 : r_winner + IW'(1);
    end
  end

  assign bus.ch_ack        = r_ack;
  assign bus.rd_fifo_wreq  = r_wreq;
  assign bus.rd_fifo_wdata = r_wdata;
  assign bus.grant_ch      = r_grant;
  assign bus.credit_err    = r_credit_err;
  assign bus.busy          = w_busy;

endmodule

// File: tb/tb_ddr3_rd_req_sched.sv
// Bench for ddr3_rd_req_sched: directed scenarios plus a random run, all
// checked every cycle against an issue-schedule reference model.
module tb_ddr3_rd_req_sched;
  localparam int NUM_CH  = 4;
  localparam int DW      = 36;
  localparam int CMAX    = 8;
  localparam int CW      = 4;
  localparam int MIN_GAP = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ddr3_rd_req_sched_if #(.NUM_CH(NUM_CH), .DW(DW)) bus ();

  ddr3_rd_req_sched #(
    .NUM_CH(NUM_CH), .DW(DW), .CREDIT_MAX(CMAX), .CW(CW), .MIN_GAP(MIN_GAP)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: issues are points on a timeline. An issue decided at edge e
  // writes after edge e+1, consumes credit at edge e+2, and the scheduler may
  // decide again at edge e+3+MIN_GAP.
  int            m_cred [NUM_CH];
  int            m_ptr, m_x, m_pe, m_pch, m_next, m_grant;
  bit            m_err;
  logic [DW-1:0] m_wdata;

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) m_cred[k] = CMAX;
    m_ptr = 0; m_x = 0; m_pe = -100; m_pch = 0; m_next = 0;
    m_grant = 0; m_err = 0; m_wdata = '0;
  endtask

  task automatic model_edge();
    int w;
    bit dec;
    w = -1;
    if (m_x >= m_next && !bus.rd_fifo_afull) begin
      for (int i = 0; i < NUM_CH; i++) begin
        int k;
        k = (m_ptr + i) % NUM_CH;
        if (w < 0 && bus.ch_req[k] && !bus.ch_ovf[k] && m_cred[k] > 0) w = k;
      end
      if (w >= 0) begin
        m_pe = m_x; m_pch = w; m_ptr = (w + 1) % NUM_CH; m_next = m_x + 3 + MIN_GAP;
      end
    end
    if (m_x == m_pe + 1) begin
      m_wdata = bus.ch_data[m_pch*DW +: DW];
      m_grant = m_pch;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      dec = (m_x == m_pe + 2) && (m_pch == k);
      if (dec && !bus.ch_credit_ret[k]) m_cred[k]--;
      else if (!dec && bus.ch_credit_ret[k]) begin
        if (m_cred[k] == CMAX) m_err = 1'b1;
        else m_cred[k]++;
      end
    end
    m_x++;
  endtask

  task automatic compare_outputs();
    int x;
    logic ew, eb;
    logic [NUM_CH-1:0] ea;
    x  = m_x - 1;
    ew = (x == m_pe + 1);
    ea = ew ? (NUM_CH'(1) << m_pch) : '0;
    eb = (x >= m_pe) && (x <= m_pe + 1 + MIN_GAP);
    chk("wreq", bus.rd_fifo_wreq, ew);
    chk("ack", bus.ch_ack, ea);
    chk("busy", bus.busy, eb);
    chk("wdata", bus.rd_fifo_wdata, m_wdata);
    chk("grant_ch", bus.grant_ch, m_grant);
    chk("credit_err", bus.credit_err, m_err);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic rand_data();
    for (int k = 0; k < NUM_CH; k++) begin
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      bus.ch_data[k*DW +: DW] = t[DW-1:0];
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.ch_req = '0; bus.ch_ovf = '0; bus.ch_credit_ret = '0; bus.rd_fifo_afull = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_wreq", bus.rd_fifo_wreq, 0);
    chk("rst_ack", bus.ch_ack, 0);
    chk("rst_wdata", bus.rd_fifo_wdata, 0);
    chk("rst_grant", bus.grant_ch, 0);
    chk("rst_err", bus.credit_err, 0);
    chk("rst_busy", bus.busy, 0);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int cnt, prev_t, idx, first_g;
    bit found;
    bus.ch_req = '0; bus.ch_ovf = '0; bus.ch_credit_ret = '0; bus.rd_fifo_afull = 1'b0;
    rand_data();

    // single channel drains its 8 credits, one return buys one more issue
    do_reset();
    bus.ch_req = 4'b0001;
    cnt = 0; prev_t = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (bus.rd_fifo_wreq) begin
        cnt++;
        chk("t1_ack0", bus.ch_ack, 4'b0001);
        if (cnt > 1) chk("t1_period", c - prev_t, 3 + MIN_GAP);
        prev_t = c;
      end
    end
    chk("t1_issues", cnt, CMAX);
    bus.ch_credit_ret = 4'b0001; step(); bus.ch_credit_ret = '0;
    cnt = 0;
    repeat (30) begin step(); if (bus.rd_fifo_wreq) cnt++; end
    chk("t1_after_ret", cnt, 1);

    // all channels: strict rotation, data of the granted channel
    do_reset();
    rand_data();
    bus.ch_req = 4'b1111;
    idx = 0;
    repeat (40) begin
      step();
      if (bus.rd_fifo_wreq) begin
        chk("t2_grant", bus.grant_ch, idx % NUM_CH);
        chk("t2_wdata", bus.rd_fifo_wdata, bus.ch_data[(idx % NUM_CH)*DW +: DW]);
        idx++;
      end
    end
    chk("t2_issues", idx, 8);

    // overflow blocks channel 1, then 1 and 2 alternate
    do_reset();
    bus.ch_req = 4'b0110; bus.ch_ovf = 4'b0010;
    cnt = 0;
    repeat (30) begin
      step();
      if (bus.rd_fifo_wreq) begin cnt++; chk("t3_only2", bus.grant_ch, 2); end
    end
    chk("t3_issues", cnt, 6);
    bus.ch_ovf = '0;
    cnt = 0;
    repeat (20) begin
      step();
      if (bus.rd_fifo_wreq) begin chk("t3_alt", bus.grant_ch, (cnt % 2 == 0) ? 1 : 2); cnt++; end
    end
    chk("t3_alt_issues", cnt, 4);

    // afull holds everything off; release gives wreq two edges later
    do_reset();
    bus.ch_req = 4'b1111; bus.rd_fifo_afull = 1'b1;
    cnt = 0;
    repeat (15) begin step(); if (bus.rd_fifo_wreq || bus.busy) cnt++; end
    chk("t4_held", cnt, 0);
    bus.rd_fifo_afull = 1'b0;
    step();
    chk("t4_wreq_e1", bus.rd_fifo_wreq, 0);
    chk("t4_busy_e1", bus.busy, 1);
    step();
    chk("t4_wreq_e2", bus.rd_fifo_wreq, 1);

    // ack and return together leave credit unchanged: 9 issues in total
    do_reset();
    bus.ch_req = 4'b0001;
    cnt = 0;
    repeat (80) begin
      step();
      bus.ch_credit_ret = '0;
      if (bus.rd_fifo_wreq) begin
        cnt++;
        if (cnt == 6) bus.ch_credit_ret = 4'b0001;
      end
    end
    chk("t5_issues", cnt, 9);
    chk("t5_no_err", bus.credit_err, 0);

    // return at full credit is dropped and flags a sticky error
    do_reset();
    bus.ch_credit_ret = 4'b0001; step(); bus.ch_credit_ret = '0;
    step();
    chk("t5_err_set", bus.credit_err, 1);
    bus.ch_req = 4'b0001;
    cnt = 0;
    repeat (60) begin step(); if (bus.rd_fifo_wreq) cnt++; end
    chk("t5_err_sticky", bus.credit_err, 1);
    chk("t5_max_issues", cnt, CMAX);

    // reset in the middle of a write
    do_reset();
    bus.ch_req = 4'b0001;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      if (bus.rd_fifo_wreq) found = 1;
    end
    chk("t6_wreq_seen", found, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_wreq_drop", bus.rd_fifo_wreq, 0);
    chk("t6_ack_drop", bus.ch_ack, 0);
    chk("t6_busy_drop", bus.busy, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    bus.ch_req = 4'b1111;
    first_g = -1;
    repeat (10) begin
      step();
      if (bus.rd_fifo_wreq && first_g < 0) first_g = int'(bus.grant_ch);
    end
    chk("t6_first_grant", first_g, 0);

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bus.ch_req = NUM_CH'($urandom());
      bus.ch_ovf = ($urandom_range(0, 7) == 0) ? NUM_CH'($urandom()) : '0;
      for (int k = 0; k < NUM_CH; k++) bus.ch_credit_ret[k] = ($urandom_range(0, 3) == 0);
      bus.rd_fifo_afull = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) rand_data();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
